i2c_pcf8574_target: RTL and testbench
=====================================

// Module: i2c_pcf8574_target
// PURPOSE
//   I2C target that emulates a PCF8574 8-bit quasi-bidirectional I/O expander.
//   It is the bus-side counterpart of our I2C master/LCD driver.
//   Used as an on-FPGA bus model (loopback tests, LCD backpack emulation) and as a
//   reusable target when the board exposes an expander-style register to an external master.
//   Write bytes land on port_out. Reads return a snapshot of port_in.
// PARAMETERS
//   I2C_ADDR     7'h27   7-bit target address (0x3F for the -A variant)
//   SYNC_STAGES  2       synchronizer flops on scl_in/sda_in (>=2)
//   PORT_RESET   8'hFF   port_out value after reset (PCF8574 power-on = all high)
// PORTS
//   clk          in   1  system clock, 100 MHz; must be >= 20x SCL
//   rst          in   1  reset, asynchronous, active-high
//   scl_in       in   1  SCL pad input (async)
//   sda_in       in   1  SDA pad input (async)
//   sda_oe       out  1  1 = pull SDA low (open drain); 0 = release
//   port_out     out  8  last data byte written (P7..P0; LCD map D7..D4,BL,E,RW,RS)
//   port_in      in   8  value returned on read
//   port_strobe  out  1  1-clk pulse when port_out is updated
//   busy         out  1  high from own-address ACK until STOP/START
// BEHAVIOUR
//   Reset values: sda_oe=0, port_out=PORT_RESET, port_strobe=0, busy=0, state=IDLE.
//   Reset is async: sda_oe releases in the same cycle rst rises, including mid-ACK.
//   Bus conditions:
//   - scl_s/sda_s are the synchronized inputs; edges are taken against the previous sample.
//   - START = sda_s fall while scl_s high. STOP = sda_s rise while scl_s high.
//   - START/STOP are legal in any state and have priority over everything else.
//   - START (incl. repeated) -> ADDR, bit_cnt=0, release SDA, drop busy, discard partial byte.
//   - STOP -> IDLE, release SDA, busy=0.
//   Bit timing: target samples SDA on SCL rise and changes sda_oe only on SCL fall.
//   States:
//   - IDLE: ignore bus until START.
//   - ADDR: shift 8 bits MSB first ({addr[6:0], R/W}).
//     - On the SCL fall after the 8th rise, on address match: sda_oe=1 -> ADDR_ACK, busy=1.
//     - On mismatch: -> IGNORE.
//   - ADDR_ACK: on the next SCL fall:
//     - R/W=0 -> WRITE, release.
//     - R/W=1 -> READ: load shreg<=port_in, sda_oe=~port_in[7].
//   - WRITE: shift 8 bits. On the SCL fall after the 8th rise:
//     - port_out<=byte, port_strobe=1 for one clk, sda_oe=1 -> WRITE_ACK.
//     - Every byte is ACKed; there is no limit on byte count.
//   - WRITE_ACK: next SCL fall -> release, WRITE, bit_cnt=0.
//   - READ: on each SCL fall, present the next bit (sda_oe=~bit).
//     - After the 8th bit's fall: release -> READ_ACK.
//   - READ_ACK: sample master SDA on SCL rise.
//     - 0 (ACK): on fall, reload shreg<=port_in and drive bit7 -> READ.
//     - 1 (NACK): -> IGNORE.
//   - IGNORE: sda_oe=0; wait for START/STOP.
//   Latency: sda_oe changes SYNC_STAGES+1 clk after the pad SCL fall (<=30 ns at 100 MHz).
//   This is well inside the 100 kHz tLOW.
//   bit_cnt is 3 bits and wraps 7->0 on byte completion.
//   port_in is sampled only at byte load, never mid-byte.
//   A STOP/START arriving mid-ACK releases SDA on the detection cycle.
// STRUCTURE
//   Shared package i2c_pkg (header i2c_pkg.vh) holds:
//   - state encoding localparams;
//   - I2C_ACK=1'b0 and I2C_NACK=1'b1;
//   - PCF8574 LCD bit map: BL=3, EN=2, RW=1, RS=0.
//   The master side uses the same header.
//   Sub-module i2c_bus_cond: synchronizer plus scl_rise/scl_fall/start/stop pulses.
//   Everything else stays in this module.
// TESTING
//   1. START, 0x4E, 0x3C, STOP -> ACK on both bytes, port_out=0x3C, one port_strobe, busy 0 after STOP.
//   2. START, 0x7E (addr 0x3F), 0x55, STOP -> sda_oe never 1, port_out stays 0xFF, no strobe.
//   3. port_in=0xA5; START, 0x4F, master clocks 8 bits + NACK, STOP -> master reads 0xA5, SDA released at ACK slot.
//   4. START, 0x4E, 0x3C, 0x38, 0x7C, STOP -> 3 ACKs, 3 strobes, port_out=0x7C.
//   5. START, 0x4E, 4 data bits, repeated START, 0x4E, 0x11, STOP -> no strobe for partial byte, port_out=0x11.
//   6. rst pulse while target drives ACK -> sda_oe=0 same cycle, port_out=0xFF, next transaction ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM encoding, ACK/NACK levels and the
// PCF8574 LCD-backpack bit map used by both the master and target sides.
package i2c_pkg;

  // Target FSM state encoding (also exported on the debug port).
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_IGNORE    = 3'd7
  } i2c_state_t;

  // SDA level in the ninth (acknowledge) bit slot.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // PCF8574 LCD backpack pin map (P7..P4 carry D7..D4).
  localparam int LCD_BL = 3;
  localparam int LCD_EN = 2;
  localparam int LCD_RW = 1;
  localparam int LCD_RS = 0;

  // True when the first byte after START carries our 7-bit address.
  function automatic logic addr_match(input logic [7:0] first_byte,
                                      input logic [6:0] own_addr);
    return first_byte[7:1] == own_addr;
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronizes the SCL/SDA pads into the clk domain and derives single-cycle
// SCL edge and START/STOP condition pulses against the previous sample.
module i2c_bus_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl_s;
  logic                   w_sda_s;

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one sample of history; reset to the idle-high bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl_s;
      r_sda_prev <= w_sda_s;
    end
  end

  assign o_scl      = w_scl_s;
  assign o_sda      = w_sda_s;
  assign o_scl_rise = w_scl_s & ~r_scl_prev;
  assign o_scl_fall = ~w_scl_s & r_scl_prev;
  // SDA may only move while SCL is high for a bus condition, so SCL must be
  // high on both samples.
  assign o_start    = w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
  assign o_stop     = w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;

endmodule

// File: rtl/i2c_pcf8574_target.sv
// I2C target emulating a PCF8574 8-bit quasi-bidirectional expander.
// Written bytes appear on port_out; reads return a byte-load snapshot of port_in.
// Bus handshake: there is no valid/ready pair; port_strobe is a one-clk
// qualifier meaning port_out has just taken a new byte, and it is never stalled.
module i2c_pcf8574_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h27,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PORT_RESET  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] port_out,
  input  logic [7:0] port_in,
  output logic       port_strobe,
  output logic       busy,
  output i2c_state_t o_dbg_state
);

  logic       w_scl_s;
  logic       w_sda_s;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;

  i2c_state_t r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shreg;
  logic       r_byte_done;
  logic       r_rw;
  logic       r_sda_oe;
  logic [7:0] r_port_out;
  logic       r_strobe;
  logic       r_busy;

  i2c_state_t w_state_nx;
  logic [2:0] w_bit_cnt_nx;
  logic [7:0] w_shreg_nx;
  logic       w_byte_done_nx;
  logic       w_rw_nx;
  logic       w_sda_oe_nx;
  logic [7:0] w_port_out_nx;
  logic       w_strobe_nx;
  logic       w_busy_nx;

  i2c_bus_cond #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_cond (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_scl      (w_scl_s),
    .o_sda      (w_sda_s),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // State and datapath registers; async reset releases SDA immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shreg     <= 8'h00;
      r_byte_done <= 1'b0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_port_out  <= PORT_RESET;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_shreg     <= w_shreg_nx;
      r_byte_done <= w_byte_done_nx;
      r_rw        <= w_rw_nx;
      r_sda_oe    <= w_sda_oe_nx;
      r_port_out  <= w_port_out_nx;
      r_strobe    <= w_strobe_nx;
      r_busy      <= w_busy_nx;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  // Data is sampled on SCL rise; SDA drive only changes on SCL fall.
  always_comb begin
    w_state_nx     = r_state;
    w_bit_cnt_nx   = r_bit_cnt;
    w_shreg_nx     = r_shreg;
    w_byte_done_nx = r_byte_done;
    w_rw_nx        = r_rw;
    w_sda_oe_nx    = r_sda_oe;
    w_port_out_nx  = r_port_out;
    w_strobe_nx    = 1'b0;
    w_busy_nx      = r_busy;

    if (w_start) begin
      // Also covers repeated START: any partial byte is dropped.
      w_state_nx     = ST_ADDR;
      w_bit_cnt_nx   = 3'd0;
      w_byte_done_nx = 1'b0;
      w_sda_oe_nx    = 1'b0;
      w_busy_nx      = 1'b0;
    end else if (w_stop) begin
      w_state_nx     = ST_IDLE;
      w_bit_cnt_nx   = 3'd0;
      w_byte_done_nx = 1'b0;
      w_sda_oe_nx    = 1'b0;
      w_busy_nx      = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end

        ST_ADDR, ST_WRITE: begin
          if (w_scl_rise) begin
            w_shreg_nx   = {r_shreg[6:0], w_sda_s};
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_byte_done_nx = 1'b1;
          end else if (w_scl_fall && r_byte_done) begin
            w_byte_done_nx = 1'b0;
            if (r_state == ST_ADDR) begin
              if (addr_match(r_shreg, I2C_ADDR)) begin
                w_sda_oe_nx = 1'b1;
                w_busy_nx   = 1'b1;
                w_rw_nx     = r_shreg[0];
                w_state_nx  = ST_ADDR_ACK;
              end else begin
                w_state_nx = ST_IGNORE;
              end
            end else begin
              w_port_out_nx = r_shreg;
              w_strobe_nx   = 1'b1;
              w_sda_oe_nx   = 1'b1;
              w_state_nx    = ST_WRITE_ACK;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bit_cnt_nx = 3'd0;
            if (r_rw) begin
              w_shreg_nx  = port_in;
              w_sda_oe_nx = ~port_in[7];
              w_state_nx  = ST_READ;
            end else begin
              w_sda_oe_nx = 1'b0;
              w_state_nx  = ST_WRITE;
            end
          end
        end

        ST_WRITE_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nx  = 1'b0;
            w_bit_cnt_nx = 3'd0;
            w_state_nx   = ST_WRITE;
          end
        end

        ST_READ: begin
          // Bit 7 is already on the bus at entry; each fall moves to the next.
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              w_sda_oe_nx  = 1'b0;
              w_bit_cnt_nx = 3'd0;
              w_state_nx   = ST_READ_ACK;
            end else begin
              w_shreg_nx   = {r_shreg[6:0], 1'b0};
              w_sda_oe_nx  = ~r_shreg[6];
              w_bit_cnt_nx = r_bit_cnt + 3'd1;
            end
          end
        end

        ST_READ_ACK: begin
          if (w_scl_rise && (w_sda_s == I2C_NACK)) begin
            w_state_nx = ST_IGNORE;
          end else if (w_scl_fall) begin
            w_shreg_nx   = port_in;
            w_sda_oe_nx  = ~port_in[7];
            w_bit_cnt_nx = 3'd0;
            w_state_nx   = ST_READ;
          end
        end

        ST_IGNORE: begin
          w_sda_oe_nx = 1'b0;
        end

        default: begin
          w_state_nx  = ST_IDLE;
          w_sda_oe_nx = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe      = r_sda_oe;
  assign port_out    = r_port_out;
  assign port_strobe = r_strobe;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_pcf8574_target.sv
// Bench for i2c_pcf8574_target: a bit-banged I2C master drives the
// open-drain bus; written bytes are scoreboarded against port_strobe events.
module tb_i2c_pcf8574_target;
  import i2c_pkg::*;

  localparam int Q = 25;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;   // master drive: 0 = pull low, 1 = release
  logic [7:0] port_in;
  logic       sda_oe;
  logic [7:0] port_out;
  logic       port_strobe;
  logic       busy;
  i2c_state_t dbg_state;
  logic       sda_line;

  int         n_checks = 0;
  int         n_errors = 0;
  int         strobe_cnt = 0;
  int         exp_strobes = 0;
  logic       oe_seen = 1'b0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign sda_line = m_sda & ~sda_oe;

  i2c_pcf8574_target #(
    .I2C_ADDR    (7'h27),
    .SYNC_STAGES (2),
    .PORT_RESET  (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (m_scl),
    .sda_in      (sda_line),
    .sda_oe      (sda_oe),
    .port_out    (port_out),
    .port_in     (port_in),
    .port_strobe (port_strobe),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (port_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) check("strobe_unexpected", 32'(1), 32'(0));
      else check("port_out_write", 32'(port_out), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = sda_line; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  // Data byte expected to land on port_out.
  task automatic write_data(input string tag, input logic [7:0] d);
    logic ack;
    exp_q.push_back(d);
    exp_strobes++;
    write_byte(d, ack);
    check(tag, 32'(ack), 32'(I2C_ACK));
  endtask

  task automatic read_byte(output logic [7:0] d, input int change_after, input logic [7:0] new_in);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
      if ((7 - i) == change_after) port_in = new_in;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       ack;
    logic [7:0] rd;
    int         s0;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; port_in = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_port_out", 32'(port_out), 32'(8'hFF));
    check("rst_strobe", 32'(port_strobe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Foreign address 0x3F: never acknowledged, no port update.
    oe_seen = 1'b0; s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h7E, ack);
    check("t2_addr_nack", 32'(ack), 32'(I2C_NACK));
    check("t2_state_ignore", 32'(dbg_state), 32'(ST_IGNORE));
    write_byte(8'h55, ack);
    check("t2_data_nack", 32'(ack), 32'(I2C_NACK));
    i2c_stop();
    check("t2_oe_never", 32'(oe_seen), 32'(0));
    check("t2_port_out", 32'(port_out), 32'(8'hFF));
    check("t2_no_strobe", 32'(strobe_cnt - s0), 32'(0));
    check("t2_busy", 32'(busy), 32'(0));

    // Single-byte write.
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h4E, ack);
    check("t1_addr_ack", 32'(ack), 32'(I2C_ACK));
    check("t1_busy_on", 32'(busy), 32'(1));
    write_data("t1_data_ack", 8'h3C);
    i2c_stop();
    check("t1_port_out", 32'(port_out), 32'(8'h3C));
    check("t1_one_strobe", 32'(strobe_cnt - s0), 32'(1));
    check("t1_busy_off", 32'(busy), 32'(0));
    check("t1_state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Read: port_in changes mid-byte (must not leak), master ACKs, then NACKs.
    port_in = 8'hA5;
    i2c_start();
    write_byte(8'h4F, ack);
    check("t3_addr_ack", 32'(ack), 32'(I2C_ACK));
    read_byte(rd, 1, 8'h3C);
    check("t3_read0", 32'(rd), 32'(8'hA5));
    write_bit(I2C_ACK);
    read_byte(rd, 8, 8'h00);
    check("t3_read1", 32'(rd), 32'(8'h3C));
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    check("t3_ack_slot_release", 32'(sda_oe), 32'(0));
    wait_q();
    m_scl = 1'b0; wait_q();
    check("t3_state_ignore", 32'(dbg_state), 32'(ST_IGNORE));
    i2c_stop();
    check("t3_busy_off", 32'(busy), 32'(0));

    // Multi-byte write.
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h4E, ack);
    check("t4_addr_ack", 32'(ack), 32'(I2C_ACK));
    write_data("t4_ack0", 8'h3C);
    write_data("t4_ack1", 8'h38);
    write_data("t4_ack2", 8'h7C);
    i2c_stop();
    check("t4_strobes", 32'(strobe_cnt - s0), 32'(3));
    check("t4_port_out", 32'(port_out), 32'(8'h7C));

    // Partial byte aborted by repeated START.
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h4E, ack);
    check("t5_addr_ack", 32'(ack), 32'(I2C_ACK));
    for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
    i2c_start();
    check("t5_rs_busy", 32'(busy), 32'(0));
    check("t5_rs_no_strobe", 32'(strobe_cnt - s0), 32'(0));
    write_byte(8'h4E, ack);
    check("t5_addr2_ack", 32'(ack), 32'(I2C_ACK));
    write_data("t5_data_ack", 8'h11);
    i2c_stop();
    check("t5_port_out", 32'(port_out), 32'(8'h11));
    check("t5_one_strobe", 32'(strobe_cnt - s0), 32'(1));

    // Reset pulse while the target holds the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(logic'((8'h4E >> i) & 8'h01));
    check("t6_acking", 32'(sda_oe), 32'(1));
    check("t6_state_addr_ack", 32'(dbg_state), 32'(ST_ADDR_ACK));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_release", 32'(sda_oe), 32'(0));
    check("t6_rst_port_out", 32'(port_out), 32'(8'hFF));
    check("t6_rst_busy", 32'(busy), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    i2c_start();
    write_byte(8'h4E, ack);
    check("t6_addr_ack", 32'(ack), 32'(I2C_ACK));
    write_data("t6_data_ack", 8'($urandom_range(0, 255)));
    i2c_stop();

    repeat (10) @(posedge clk);
    #1;
    check("sb_queue_empty", 32'(exp_q.size()), 32'(0));
    check("sb_strobe_total", 32'(strobe_cnt), 32'(exp_strobes));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
